// File: rtl/vga_timing_prog.sv
// Runtime-programmable VGA timing generator: counters, blanking, sync and strobes.
// A new mode is held in a shadow register and takes effect only at the (0,0) wrap.
module vga_timing_prog #(
    parameter int CNT_W        = 11,
    parameter int H_TOTAL      = 1056,
    parameter int H_ACTIVE     = 800,
    parameter int H_SYNC_START = 840,
    parameter int H_SYNC_STOP  = 968,
    parameter int V_TOTAL      = 628,
    parameter int V_ACTIVE     = 600,
    parameter int V_SYNC_START = 601,
    parameter int V_SYNC_STOP  = 605,
    parameter int H_POL        = 1,
    parameter int V_POL        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_h_total,
    input  logic [CNT_W-1:0] cfg_h_active,
    input  logic [CNT_W-1:0] cfg_h_sync_start,
    input  logic [CNT_W-1:0] cfg_h_sync_stop,
    input  logic [CNT_W-1:0] cfg_v_total,
    input  logic [CNT_W-1:0] cfg_v_active,
    input  logic [CNT_W-1:0] cfg_v_sync_start,
    input  logic [CNT_W-1:0] cfg_v_sync_stop,
    input  logic             cfg_h_pol,
    input  logic             cfg_v_pol,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);

    typedef struct packed {
        logic [CNT_W-1:0] h_total;
        logic [CNT_W-1:0] h_active;
        logic [CNT_W-1:0] h_sync_start;
        logic [CNT_W-1:0] h_sync_stop;
        logic [CNT_W-1:0] v_total;
        logic [CNT_W-1:0] v_active;
        logic [CNT_W-1:0] v_sync_start;
        logic [CNT_W-1:0] v_sync_stop;
        logic             h_pol;
        logic             v_pol;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        h_total:      CNT_W'(H_TOTAL),
        h_active:     CNT_W'(H_ACTIVE),
        h_sync_start: CNT_W'(H_SYNC_START),
        h_sync_stop:  CNT_W'(H_SYNC_STOP),
        v_total:      CNT_W'(V_TOTAL),
        v_active:     CNT_W'(V_ACTIVE),
        v_sync_start: CNT_W'(V_SYNC_START),
        v_sync_stop:  CNT_W'(V_SYNC_STOP),
        h_pol:        1'(H_POL),
        v_pol:        1'(V_POL)
    };

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    // A CNT_W-bit total can never exceed 2^CNT_W, so only the ordering rules need checking.
    function automatic logic axis_ok(input logic [CNT_W-1:0] total,
                                     input logic [CNT_W-1:0] active,
                                     input logic [CNT_W-1:0] sync_start,
                                     input logic [CNT_W-1:0] sync_stop);
        return (active != '0) && (active <= sync_start) && (sync_start < sync_stop) &&
               (sync_stop <= total) && (total >= TWO);
    endfunction

    cfg_t             act_q, act_d;
    cfg_t             sh_q, sh_d;
    cfg_t             cfg_in;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;
    logic             h_wrap, v_wrap, frame_wrap, apply, cfg_ok;

    always_comb begin
        cfg_in = '{
            h_total:      cfg_h_total,
            h_active:     cfg_h_active,
            h_sync_start: cfg_h_sync_start,
            h_sync_stop:  cfg_h_sync_stop,
            v_total:      cfg_v_total,
            v_active:     cfg_v_active,
            v_sync_start: cfg_v_sync_start,
            v_sync_stop:  cfg_v_sync_stop,
            h_pol:        cfg_h_pol,
            v_pol:        cfg_v_pol
        };
        cfg_ok = axis_ok(cfg_h_total, cfg_h_active, cfg_h_sync_start, cfg_h_sync_stop) &&
                 axis_ok(cfg_v_total, cfg_v_active, cfg_v_sync_start, cfg_v_sync_stop);
    end

    always_comb begin
        h_wrap     = (hcount_q == act_q.h_total - ONE);
        v_wrap     = (vcount_q == act_q.v_total - ONE);
        frame_wrap = en && h_wrap && v_wrap;
        apply      = frame_wrap && pend_q;

        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (en) begin
            hcount_d = h_wrap ? '0 : hcount_q + ONE;
            if (h_wrap) begin
                vcount_d = v_wrap ? '0 : vcount_q + ONE;
            end
        end

        // The old shadow is applied even if a new load lands on this same edge.
        act_d  = apply ? sh_q : act_q;
        sh_d   = sh_q;
        pend_d = pend_q;
        if (cfg_load && cfg_ok) begin
            sh_d   = cfg_in;
            pend_d = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end
        err_d = cfg_load && !cfg_ok;

        hblnk_d = hblnk_q;
        vblnk_d = vblnk_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        if (en) begin
            hblnk_d = (hcount_d >= act_d.h_active);
            vblnk_d = (vcount_d >= act_d.v_active);
            hsync_d = ((hcount_d >= act_d.h_sync_start) && (hcount_d < act_d.h_sync_stop)) ?
                      act_d.h_pol : !act_d.h_pol;
            vsync_d = ((vcount_d >= act_d.v_sync_start) && (vcount_d < act_d.v_sync_stop)) ?
                      act_d.v_pol : !act_d.v_pol;
            de_d    = !hblnk_d && !vblnk_d;
        end

        ls_d = en && h_wrap;
        fs_d = frame_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q    <= CFG_DEFAULT;
            sh_q     <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            hsync_q  <= !CFG_DEFAULT.h_pol;
            vsync_q  <= !CFG_DEFAULT.v_pol;
            de_q     <= 1'b0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            act_q    <= act_d;
            sh_q     <= sh_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign cfg_pending = pend_q;
    assign cfg_err     = err_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: doc/vga_timing_prog.md
Name: vga_timing_prog

Overview:
- Runtime-programmable successor to the fixed-mode VGA timing generator. Produces hcount/vcount, blanking, sync and frame/line strobes for any mode that fits in CNT_W bits.
- A new mode is loaded through a shadow-register handshake and takes effect only at a frame boundary, so the monitor never sees a torn frame.
- Adds a pixel-clock enable, per-axis sync polarity and a data-enable output.
- Sits at the head of the video pipeline and feeds the downstream draw stages.

Parameters:
- CNT_W, 11, width of counters and timing fields
- H_TOTAL, 1056, reset-default pixels per line
- H_ACTIVE, 800, reset-default visible pixels (horizontal blank starts here)
- H_SYNC_START, 840, reset-default hsync first pixel
- H_SYNC_STOP, 968, reset-default first pixel after hsync
- V_TOTAL, 628, reset-default lines per frame
- V_ACTIVE, 600, reset-default visible lines
- V_SYNC_START, 601, reset-default vsync first line
- V_SYNC_STOP, 605, reset-default first line after vsync
- H_POL, 1, reset-default hsync polarity (1 = active-high)
- V_POL, 1, reset-default vsync polarity

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  pixel enable; counters advance only when high
- cfg_load  in  1  one-cycle strobe capturing all cfg_* inputs
- cfg_h_total, cfg_h_active, cfg_h_sync_start, cfg_h_sync_stop  in  CNT_W each  new horizontal timing
- cfg_v_total, cfg_v_active, cfg_v_sync_start, cfg_v_sync_stop  in  CNT_W each  new vertical timing
- cfg_h_pol, cfg_v_pol  in  1 each  new sync polarities
- cfg_pending  out  1  valid config waiting for the frame boundary
- cfg_err  out  1  one-cycle pulse: rejected cfg_load
- hcount, vcount  out  CNT_W  current pixel position
- hblnk, vblnk  out  1  blanking flags
- hsync, vsync  out  1  sync outputs, polarity applied
- de  out  1  ~hblnk & ~vblnk
- line_start, frame_start  out  1  one-cycle strobes

Behaviour:
- Reset (async assert, sync release):
  - hcount = vcount = 0; hblnk = vblnk = de = 0.
  - hsync = ~H_POL, vsync = ~V_POL (inactive level).
  - cfg_pending = cfg_err = line_start = frame_start = 0.
  - Active config = parameter defaults; shadow register cleared.
- Advance, on a clk edge with en = 1:
  - hcount = (hcount == h_total-1) ? 0 : hcount+1.
  - vcount increments when hcount wraps; it wraps to 0 when it is at v_total-1 and hcount also wraps.
  - With en = 0 every output holds, strobes excepted.
- All outputs are registered and consistent with the count pair shown in the same cycle:
  - hblnk = (hcount >= h_active); vblnk = (vcount >= v_active).
  - hsync active when h_sync_start <= hcount < h_sync_stop; vsync active when v_sync_start <= vcount < v_sync_stop. Active level = pol, inactive = ~pol.
- Strobes:
  - line_start = 1 for exactly one cycle after an en-qualified edge that moved hcount to 0.
  - frame_start = 1 likewise when the edge moved both counts to (0,0).
  - Neither strobe fires on reset release.
- Config validation, evaluated on the cfg_load cycle. A config is legal only if, per axis:
  - 0 < active <= sync_start < sync_stop <= total
  - total >= 2
  - total <= 2^CNT_W
- Legal cfg_load: the shadow register captures the inputs and cfg_pending = 1 on the next cycle.
- Illegal cfg_load: cfg_err pulses one cycle; the shadow register and cfg_pending are unchanged.
- cfg_load while pending (legal) overwrites the shadow register; last write wins.
- Application point: the en-qualified edge that wraps to (0,0) with cfg_pending = 1.
  - That same edge copies shadow to active and clears cfg_pending.
  - Outputs after that edge already use the new config. frame_start still pulses.
- cfg_load on the application edge: the new legal values go to shadow and cfg_pending stays 1; the old shadow is applied.
- Counters never exceed the active total-1. No out-of-range state exists, because totals change only at (0,0).
- Reset mid-frame or while pending discards the shadow register and restores the defaults.

Test Plan:
- Reset defaults, en = 1 for 1056*628 cycles:
  - hblnk rises at hcount = 800; hsync high for hcount 840..967.
  - vsync high for vcount 601..604.
  - frame_start pulses once per 663168 cycles; line_start every 1056.
- Legal cfg_load (h 10/6/7/9, v 5/3/4/5, pol 0/0) mid-frame:
  - cfg_pending = 1 until the default frame ends, then 0.
  - Following frame is 50 cycles.
  - hsync low only at hcount 7..8; vsync low only on line 4; de = 1 for 18 cycles per frame.
- Illegal cfg_load (h_sync_stop = 11 > h_total = 10): cfg_err pulses one cycle; cfg_pending stays 0; timing unchanged.
- Two legal loads before the boundary (h_total 10, then 12): the applied frame uses 12.
- en toggled 1/0 alternately: counts advance every other cycle; strobes are one cycle wide; sync widths double in clk cycles.
- Assert rst at hcount = 5, vcount = 2 with cfg_pending = 1: all outputs at reset values immediately; defaults restored; cfg_pending = 0.
